ntt_pointwise_seq: RTL and testbench

Sequential, memory-attached pointwise multiplier for NTT-domain polynomials. It computes C[i] = (A[i] * B[i]) mod Q one coefficient per cycle. It reads A and B from synchronous coefficient RAMs and writes C back through a write port. It is the memory-side counterpart of the fully parallel pointwise array: it trades N multipliers for one pipelined `mod_mult` and an address sequencer. It sits between the forward-NTT output buffers and the inverse-NTT input buffer.

---
 rtl/ntt_pkg.sv | 38 +++
 rtl/mod_mult.sv | 121 ++++++++++++
 rtl/ntt_pointwise_seq.sv | 192 +++++++++++++++++++
 tb/tb_ntt_pointwise_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg -- definitions shared by the NTT datapath blocks.
//
// Contents:
//   pw_state_t      sequencer states of the memory-attached pointwise multiplier
//   RED_*           reduction-type selectors understood by mod_mult
//   mod_add()       (a + b) mod q for a, b < q; used by the pointwise
//                   accumulate mode and by the butterfly
package ntt_pkg;

  typedef enum logic [1:0] {
    PW_IDLE  = 2'd0,
    PW_RUN   = 2'd1,
    PW_DRAIN = 2'd2,
    PW_DONE  = 2'd3
  } pw_state_t;

  localparam int RED_SIMPLE     = 0;
  localparam int RED_BARRETT    = 1;
  localparam int RED_MONTGOMERY = 2;

  // Widest coefficient mod_add supports; callers zero-extend into it.
  localparam int MOD_ADD_W = 64;

  // Modular add for operands already reduced below q. The sum is formed one
  // bit wider than the operands so the carry is never lost, then a single
  // conditional subtract brings it back below q.
  function automatic logic [MOD_ADD_W-1:0] mod_add(
    input logic [MOD_ADD_W-1:0] a,
    input logic [MOD_ADD_W-1:0] b,
    input logic [MOD_ADD_W-1:0] q
  );
    logic [MOD_ADD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return MOD_ADD_W'(s);
  endfunction

endpackage

// File: rtl/mod_mult.sv
// mod_mult -- combinational modular multiplier, res = (a * b) mod Q.
//
// Parameters:
//   WIDTH           port width of operands and result
//   Q               modulus, Q < 2^WIDTH, not a power of two (NTT primes are odd)
//   REDUCTION_TYPE  RED_SIMPLE (% operator), RED_BARRETT, RED_MONTGOMERY
//
// Ports:
//   a, b   in   WIDTH   operands, both < Q
//   res    out  WIDTH   product reduced into [0, Q)
//
// Operands are narrowed to QW = clog2(Q) bits, which holds any value < Q.
// The Montgomery variant applies a second REDC against R^2 mod Q so the
// result is in the ordinary domain and all three variants are interchangeable.
module mod_mult
  import ntt_pkg::*;
#(
  parameter int          WIDTH          = 32,
  parameter int unsigned Q              = 3329,
  parameter int          REDUCTION_TYPE = RED_BARRETT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  localparam int QW = $clog2(Q);
  localparam int PW = 2 * QW;

  // floor(2^(2*QW) / Q); fits in QW+2 bits because Q > 2^(QW-1).
  function automatic logic [QW+1:0] barrett_mu();
    logic [PW:0] num;
    num     = '0;
    num[PW] = 1'b1;
    return (QW+2)'(num / (PW+1)'(Q));
  endfunction

  // -Q^-1 mod 2^QW via Newton iteration; each step doubles the correct bits,
  // starting from 3 correct bits since Q*Q == 1 mod 8 for odd Q.
  function automatic logic [QW-1:0] mont_qinv_neg();
    logic [63:0] qq;
    logic [63:0] inv;
    qq  = 64'(Q);
    inv = qq;
    for (int i = 0; i < 6; i++) inv = inv * (64'd2 - qq * inv);
    return QW'(64'd0 - inv);
  endfunction

  // R^2 mod Q with R = 2^QW.
  function automatic logic [QW-1:0] mont_r2();
    logic [63:0] rm;
    rm = (64'd1 << QW) % 64'(Q);
    return QW'((rm * rm) % 64'(Q));
  endfunction

  // Montgomery reduction: t * R^-1 mod Q for t < Q*R.
  function automatic logic [QW-1:0] mont_redc(
    input logic [PW-1:0] t,
    input logic [QW-1:0] qinv_neg
  );
    logic [QW-1:0] m;
    logic [PW:0]   s;
    logic [QW:0]   u;
    m = QW'(t) * qinv_neg;
    // Low QW bits of s are zero by choice of m, so the shift is exact.
    s = (PW+1)'(t) + (PW+1)'(m) * (PW+1)'(Q);
    u = (QW+1)'(s >> QW);
    if (u >= (QW+1)'(Q)) u = u - (QW+1)'(Q);
    return QW'(u);
  endfunction

  logic [QW-1:0] a_q;
  logic [QW-1:0] b_q;
  logic [PW-1:0] prod;

  assign a_q  = QW'(a);
  assign b_q  = QW'(b);
  assign prod = PW'(a_q) * PW'(b_q);

  if (REDUCTION_TYPE == RED_BARRETT) begin : g_barrett
    localparam logic [QW+1:0] MU = barrett_mu();
    localparam logic [PW-1:0] QP = PW'(Q);
    localparam logic [QW+1:0] QX = (QW+2)'(Q);

    logic [PW+QW+1:0] pm;
    logic [QW+1:0]    qe;
    logic [PW-1:0]    r0;
    logic [QW+1:0]    r1;
    logic [QW+1:0]    r2;
    logic [QW+1:0]    r3;

    // The quotient estimate undershoots by at most 2, so r0 < 3Q and two
    // conditional subtracts finish the reduction.
    assign pm  = (PW+QW+2)'(prod) * (PW+QW+2)'(MU);
    assign qe  = (QW+2)'(pm >> PW);
    assign r0  = prod - PW'(qe) * QP;
    assign r1  = (QW+2)'(r0);
    assign r2  = (r1 >= QX) ? r1 - QX : r1;
    assign r3  = (r2 >= QX) ? r2 - QX : r2;
    assign res = WIDTH'(r3);
  end else if (REDUCTION_TYPE == RED_MONTGOMERY) begin : g_montgomery
    localparam logic [QW-1:0] QINV_NEG = mont_qinv_neg();
    localparam logic [QW-1:0] R2       = mont_r2();

    logic [QW-1:0] t1;
    logic [QW-1:0] t2;

    // t1 = a*b*R^-1; multiplying by R^2 and reducing again cancels the R^-1.
    assign t1  = mont_redc(prod, QINV_NEG);
    assign t2  = mont_redc(PW'(t1) * PW'(R2), QINV_NEG);
    assign res = WIDTH'(t2);
  end else begin : g_simple
    localparam logic [PW-1:0] QP = PW'(Q);

    logic [PW-1:0] rem;

    assign rem = prod % QP;
    assign res = WIDTH'(rem);
  end

endmodule

// File: rtl/ntt_pointwise_seq.sv
// ntt_pointwise_seq -- sequential pointwise multiplier for NTT-domain
// polynomials: C[i] = (A[i] * B[i]) mod Q, one coefficient per cycle, read
// from synchronous coefficient RAMs and written back through a write port.
//
// Optional feature (macro NTT_PW_ACC_EN): accumulate mode. Adds the rd_data_c
// port and writes C[i] = (C_old[i] + A[i]*B[i]) mod Q with identical timing.
//
// Ports:
//   clk        in   1        clock
//   rst_n      in   1        synchronous active-low reset
//   start      in   1        single-cycle request, honoured only in IDLE
//   busy       out  1        first read cycle through last write cycle
//   done       out  1        one-cycle pulse after the last write
//   rd_en      out  1        read strobe to the A/B (and C) RAMs
//   rd_addr    out  log2 N   shared read index
//   rd_data_a  in   WIDTH    A[rd_addr], one cycle after rd_en
//   rd_data_b  in   WIDTH    B[rd_addr], one cycle after rd_en
//   rd_data_c  in   WIDTH    C[rd_addr], one cycle after rd_en (accumulate only)
//   wr_en      out  1        C write strobe
//   wr_addr    out  log2 N   C write index
//   wr_data    out  WIDTH    C value, always < Q
//
// Pipeline: read issued (stage 0) -> RAM data through mod_mult, registered
// with valid and index (stage 1) -> registered product drives the write
// port (stage 2). Read-to-write latency is 2 cycles; rd_addr and wr_addr
// never coincide, so B and C may share one dual-port RAM.
module ntt_pointwise_seq
  import ntt_pkg::*;
#(
  parameter int          N              = 256,
  parameter int          WIDTH          = 32,
  parameter int unsigned Q              = 3329,
  parameter int          REDUCTION_TYPE = RED_BARRETT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [$clog2(N)-1:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_data_a,
  input  logic [WIDTH-1:0]     rd_data_b,
`ifdef NTT_PW_ACC_EN
  input  logic [WIDTH-1:0]     rd_data_c,
`endif
  output logic                 wr_en,
  output logic [$clog2(N)-1:0] wr_addr,
  output logic [WIDTH-1:0]     wr_data
);

  localparam int            AW   = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  pw_state_t     state;
  pw_state_t     state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
  logic          drain;
  logic          drain_nxt;
  logic          rd_en_int;
  logic          busy_int;
  logic          done_int;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PW_IDLE;
      cnt   <= '0;
      drain <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      drain <= drain_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drain_nxt = drain;
    rd_en_int = 1'b0;
    busy_int  = 1'b0;
    done_int  = 1'b0;

    case (state)
      PW_IDLE: begin
        if (start) begin
          state_nxt = PW_RUN;
          cnt_nxt   = '0;
        end
      end
      PW_RUN: begin
        rd_en_int = 1'b1;
        busy_int  = 1'b1;
        // Terminate on the last index rather than on wrap-around, so the run
        // length does not depend on N filling the counter exactly.
        if (cnt == LAST) begin
          state_nxt = PW_DRAIN;
          cnt_nxt   = '0;
          drain_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      PW_DRAIN: begin
        // Two cycles: let the last read reach stage 1, then the write port.
        busy_int = 1'b1;
        if (drain) begin
          state_nxt = PW_DONE;
          drain_nxt = 1'b0;
        end else begin
          drain_nxt = 1'b1;
        end
      end
      PW_DONE: begin
        done_int  = 1'b1;
        state_nxt = PW_IDLE;
      end
      default: state_nxt = PW_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] c_val;

  mod_mult #(
    .WIDTH         (WIDTH),
    .Q             (Q),
    .REDUCTION_TYPE(REDUCTION_TYPE)
  ) u_mod_mult (
    .a  (rd_data_a),
    .b  (rd_data_b),
    .res(prod)
  );

`ifdef NTT_PW_ACC_EN
  // C_old and the product are both < Q, so one conditional subtract suffices.
  assign c_val = WIDTH'(mod_add(MOD_ADD_W'(rd_data_c), MOD_ADD_W'(prod),
                                MOD_ADD_W'(Q)));
`else
  assign c_val = prod;
`endif

  // Stage 1 tracks the read that is returning this cycle; stage 2 holds the
  // reduced result presented on the write port.
  logic             s1_vld;
  logic [AW-1:0]    s1_idx;
  logic             s2_vld;
  logic [AW-1:0]    s2_idx;
  logic [WIDTH-1:0] s2_data;

  // NOTE: the data registers are reset along with the valid bits because the
  // write port has defined values out of reset, not just a cleared strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_idx  <= '0;
      s2_vld  <= 1'b0;
      s2_idx  <= '0;
      s2_data <= '0;
    end else begin
      s1_vld <= rd_en_int;
      s1_idx <= cnt;
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_idx  <= s1_idx;
        s2_data <= c_val;
      end
    end
  end

  // Strobes are qualified by rst_n so that they drop in the very cycle reset
  // is asserted, not one edge later when the synchronous reset takes effect.
  assign rd_en   = rd_en_int & rst_n;
  assign busy    = busy_int & rst_n;
  assign done    = done_int & rst_n;
  assign wr_en   = s2_vld & rst_n;
  assign rd_addr = cnt;
  assign wr_addr = s2_idx;
  assign wr_data = s2_data;

endmodule

// File: tb/tb_ntt_pointwise_seq.sv
// tb_ntt_pointwise_seq -- directed bench for ntt_pointwise_seq.
// Three instances (SIMPLE, BARRETT, MONTGOMERY reduction) run in lockstep on
// the same RAM model; every cycle of every run is compared against the
// cycle-exact timing and hand-computed coefficient values.
// Build with +define+NTT_PW_ACC_EN to include the accumulate-mode vectors.
module tb_ntt_pointwise_seq;

  localparam int          N     = 256;
  localparam int          WIDTH = 32;
  localparam int unsigned Q     = 3329;
  localparam int          AW    = 8;
  localparam int          NI    = 3;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic             busy_w    [NI];
  logic             done_w    [NI];
  logic             rd_en_w   [NI];
  logic             wr_en_w   [NI];
  logic [AW-1:0]    rd_addr_w [NI];
  logic [AW-1:0]    wr_addr_w [NI];
  logic [WIDTH-1:0] wr_data_w [NI];

  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_b;
  logic [WIDTH-1:0] q_c;
  logic [WIDTH-1:0] mem_a [N];
  logic [WIDTH-1:0] mem_b [N];
  logic [WIDTH-1:0] mem_c [N];
  logic [WIDTH-1:0] exp_c [N];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ntt_pointwise_seq #(
      .N             (N),
      .WIDTH         (WIDTH),
      .Q             (Q),
      .REDUCTION_TYPE(g)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .rd_en    (rd_en_w[g]),
      .rd_addr  (rd_addr_w[g]),
      .rd_data_a(q_a),
      .rd_data_b(q_b),
`ifdef NTT_PW_ACC_EN
      .rd_data_c(q_c),
`endif
      .wr_en    (wr_en_w[g]),
      .wr_addr  (wr_addr_w[g]),
      .wr_data  (wr_data_w[g])
    );
  end

  // Synchronous-read RAM model addressed by instance 0 (all instances issue
  // identical read sequences).
  always @(posedge clk) begin
    if (rd_en_w[0]) begin
      q_a <= mem_a[rd_addr_w[0]];
      q_b <= mem_b[rd_addr_w[0]];
      q_c <= mem_c[rd_addr_w[0]];
    end
  end

  function automatic obs_t sample(input int k, input bit m_rd, input bit m_wr);
    obs_t o;
    o.busy    = busy_w[k];
    o.done    = done_w[k];
    o.rd_en   = rd_en_w[k];
    o.rd_addr = m_rd ? rd_addr_w[k] : '0;
    o.wr_en   = wr_en_w[k];
    o.wr_addr = m_wr ? wr_addr_w[k] : '0;
    o.wr_data = m_wr ? wr_data_w[k] : '0;
    return o;
  endfunction

  // kind 0: A=i B=1 -> i;  1: A=B=Q-1 -> 1;  2: A=2 B=1665 -> 1;
  // kind 3: C_old=3328 A=1 B=1 -> 0;  4: C_old=5 A=3 B=4 -> 17
  task automatic fill(input int kind);
    for (int i = 0; i < N; i++) begin
      mem_c[i] = '0;
      case (kind)
        0: begin mem_a[i] = WIDTH'(i); mem_b[i] = 32'd1;    exp_c[i] = WIDTH'(i); end
        1: begin mem_a[i] = 32'd3328;  mem_b[i] = 32'd3328; exp_c[i] = 32'd1;     end
        2: begin mem_a[i] = 32'd2;     mem_b[i] = 32'd1665; exp_c[i] = 32'd1;     end
        3: begin mem_c[i] = 32'd3328;  mem_a[i] = 32'd1;    mem_b[i] = 32'd1;
                 exp_c[i] = 32'd0;  end
        default: begin mem_c[i] = 32'd5; mem_a[i] = 32'd3; mem_b[i] = 32'd4;
                 exp_c[i] = 32'd17; end
      endcase
    end
  endtask

  // Cycle-accurate check of one run. Cycle 0 is the cycle in which start is
  // sampled; checks happen at the falling edge of cycles 1..N+5 (N+4 when
  // chaining, where start is raised again for the next run).
  task automatic run_check(input string tag, input int extra_start,
                           input bit pre_started, input bit chain_next);
    int   wr_cnt   [NI];
    int   done_cnt [NI];
    int   last;
    bit   e_rd;
    bit   e_wr;
    obs_t o;
    obs_t e;
    last = chain_next ? N + 4 : N + 5;
    for (int k = 0; k < NI; k++) begin
      wr_cnt[k]   = 0;
      done_cnt[k] = 0;
    end
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'b0;
      e_rd  = (c >= 1) && (c <= N);
      e_wr  = (c >= 3) && (c <= N + 2);
      e.busy    = (c <= N + 2);
      e.done    = (c == N + 3);
      e.rd_en   = e_rd;
      e.rd_addr = e_rd ? AW'(c - 1) : '0;
      e.wr_en   = e_wr;
      e.wr_addr = e_wr ? AW'(c - 3) : '0;
      e.wr_data = e_wr ? exp_c[e_wr ? c - 3 : 0] : '0;
      for (int k = 0; k < NI; k++) begin
        o = sample(k, e_rd, e_wr);
        n_vec++;
        if (o !== e) begin
          n_err++;
          $display("FAIL %s cycle %0d dut%0d: got %h want %h", tag, c, k, o, e);
        end
        wr_cnt[k]   += int'(wr_en_w[k]);
        done_cnt[k] += int'(done_w[k]);
      end
      if (c == extra_start) start = 1'b1;
      if (chain_next && c == last) start = 1'b1;
    end
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if (wr_cnt[k] != N) begin
        n_err++;
        $display("FAIL %s wr_en pulses dut%0d: got %0d want %0d", tag, k, wr_cnt[k], N);
      end
      n_vec++;
      if (done_cnt[k] != 1) begin
        n_err++;
        $display("FAIL %s done pulses dut%0d: got %0d want 1", tag, k, done_cnt[k]);
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      o = sample(k, 1'b1, 1'b1);
      n_vec++;
      if (o !== '0) begin
        n_err++;
        $display("FAIL reset_values dut%0d: got %h want 0", k, o);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      o = sample(k, 1'b0, 1'b0);
      n_vec++;
      if (o !== '0) begin
        n_err++;
        $display("FAIL idle_after_reset dut%0d: got %h want 0", k, o);
      end
    end
  endtask

  task automatic test_ramp();
    fill(0);
    run_check("ramp", 0, 1'b0, 1'b0);
  endtask

  task automatic test_max_operands();
    fill(1);
    run_check("q_minus_1_sq", 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_product();
    fill(2);
    run_check("two_x_1665", 0, 1'b0, 1'b0);
  endtask

  task automatic test_restart_ignored();
    fill(0);
    run_check("restart_busy", 50, 1'b0, 1'b0);
  endtask

  task automatic test_start_in_done();
    fill(1);
    run_check("start_in_done", N + 3, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill(0);
    run_check("b2b_first", 0, 1'b0, 1'b1);
    run_check("b2b_second", 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    obs_t o;
    fill(2);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    for (int c = 10; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 10) rst_n = 1'b0;
      if (c == 12) rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        o = sample(k, 1'b0, 1'b0);
        n_vec++;
        if (o !== '0) begin
          n_err++;
          $display("FAIL reset_mid cycle %0d dut%0d: got %h want 0", c, k, o);
        end
      end
    end
    fill(0);
    run_check("after_reset_mid", 0, 1'b0, 1'b0);
  endtask

`ifdef NTT_PW_ACC_EN
  task automatic test_accumulate();
    fill(3);
    run_check("acc_wrap_to_zero", 0, 1'b0, 1'b0);
    fill(4);
    run_check("acc_5_plus_12", 0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_max_operands();
    test_wrap_product();
    test_restart_ignored();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid_run();
`ifdef NTT_PW_ACC_EN
    test_accumulate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
